// File: rtl/config_pkg.sv
// Region-rule subset of the core configuration package: rule tables,
// lookup kinds and the shared address range comparator.
package config_pkg;

  localparam int unsigned NrMaxRules = 16;

  typedef enum logic [1:0] {
    NONIDEM = 2'd0,
    EXEC    = 2'd1,
    CACHE   = 2'd2,
    RSVD    = 2'd3
  } pma_kind_e;

  typedef struct packed {
    int unsigned                 NrNonIdempotentRules;
    logic [NrMaxRules-1:0][63:0] NonIdempotentAddrBase;
    logic [NrMaxRules-1:0][63:0] NonIdempotentLength;
    int unsigned                 NrExecuteRegionRules;
    logic [NrMaxRules-1:0][63:0] ExecuteRegionAddrBase;
    logic [NrMaxRules-1:0][63:0] ExecuteRegionLength;
    int unsigned                 NrCachedRegionRules;
    logic [NrMaxRules-1:0][63:0] CachedRegionAddrBase;
    logic [NrMaxRules-1:0][63:0] CachedRegionLength;
  } cva6_cfg_t;

  localparam cva6_cfg_t cva6_cfg_empty = '0;

  // The end bound is computed on 65 bits so a region touching 2^64 never wraps.
  function automatic logic range_check(logic [63:0] base, logic [63:0] len,
                                       logic [63:0] address);
    return (address >= base) && ({1'b0, address} < (65'(base) + 65'(len)));
  endfunction

endpackage

// File: rtl/pma_seq_checker_pkg.sv
// Local types and helpers for the sequential PMA region checker.
package pma_seq_checker_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int unsigned RuleCntW = 5;

  // Tables larger than the hardware index range are scanned only up to NrMaxRules.
  function automatic logic [RuleCntW-1:0] clamp_rules(int unsigned n);
    return (n > config_pkg::NrMaxRules) ? RuleCntW'(config_pkg::NrMaxRules) : RuleCntW'(n);
  endfunction

endpackage

// File: rtl/pma_rr_arbiter.sv
// Round-robin arbiter: grants the first valid requester at or after the
// priority pointer; the pointer moves past the winner on each accepted grant.
module pma_rr_arbiter #(
  parameter  int unsigned NrReq = 2,
  localparam int unsigned IdxW  = (NrReq > 1) ? $clog2(NrReq) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [NrReq-1:0] req_i,
  input  logic             ack_i,
  output logic [NrReq-1:0] gnt_o,
  output logic [IdxW-1:0]  gnt_idx_o
);

  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [IdxW-1:0] cand;
  logic            found;

  // NOTE: every variable written in a combinational block gets a default first, so no latch is inferred.
  always_comb begin
    found     = 1'b0;
    gnt_idx_o = '0;
    cand      = '0;
    for (int unsigned i = 0; i < NrReq; i++) begin
      cand = IdxW'((32'(ptr_q) + i) % NrReq);
      if (!found && req_i[cand]) begin
        found     = 1'b1;
        gnt_idx_o = cand;
      end
    end
  end

  always_comb begin
    gnt_o = '0;
    if (en_i && found) gnt_o[gnt_idx_o] = 1'b1;
  end

  assign ptr_d = (gnt_idx_o == IdxW'(NrReq - 1)) ? '0 : gnt_idx_o + IdxW'(1);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i)      ptr_q <= '0;
    else if (ack_i) ptr_q <= ptr_d;
  end

endmodule

// File: rtl/pma_seq_checker.sv
// Sequential PMA region checker: arbitrates lookups and scans one rule per
// cycle through a single shared range comparator, exiting on the first hit.
module pma_seq_checker
  import config_pkg::*;
  import pma_seq_checker_pkg::*;
#(
  parameter  config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty,
  parameter  int unsigned           NrReq   = 2,
  localparam int unsigned           IdxW    = (NrReq > 1) ? $clog2(NrReq) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NrReq-1:0]       req_valid_i,
  output logic [NrReq-1:0]       req_ready_o,
  input  logic [NrReq-1:0][63:0] req_addr_i,
  input  logic [NrReq-1:0][1:0]  req_kind_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [IdxW-1:0]        rsp_id_o,
  output logic                   rsp_hit_o,
  output logic [3:0]             rsp_rule_o
);

  state_e          state_q, state_d;
  logic [63:0]     addr_q, addr_d;
  pma_kind_e       kind_q, kind_d;
  logic [IdxW-1:0] id_q, id_d;
  logic            hit_q, hit_d;
  logic [3:0]      rule_q, rule_d;
  logic [3:0]      k_q, k_d;

  logic [NrReq-1:0]    gnt;
  logic [IdxW-1:0]     gnt_idx;
  logic                handshake;
  logic [63:0]         rule_base, rule_len;
  logic [RuleCntW-1:0] nr_rules;
  logic                rule_hit, last_rule;

  pma_rr_arbiter #(.NrReq(NrReq)) i_arb (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .en_i      (state_q == IDLE),
    .req_i     (req_valid_i),
    .ack_i     (handshake),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  assign handshake = |(req_valid_i & gnt);

  // Reserved kind falls through with zero rules, i.e. an immediate miss.
  always_comb begin
    rule_base = '0;
    rule_len  = '0;
    nr_rules  = '0;
    unique case (kind_q)
      NONIDEM: begin
        rule_base = CVA6Cfg.NonIdempotentAddrBase[k_q];
        rule_len  = CVA6Cfg.NonIdempotentLength[k_q];
        nr_rules  = clamp_rules(CVA6Cfg.NrNonIdempotentRules);
      end
      EXEC: begin
        rule_base = CVA6Cfg.ExecuteRegionAddrBase[k_q];
        rule_len  = CVA6Cfg.ExecuteRegionLength[k_q];
        nr_rules  = clamp_rules(CVA6Cfg.NrExecuteRegionRules);
      end
      CACHE: begin
        rule_base = CVA6Cfg.CachedRegionAddrBase[k_q];
        rule_len  = CVA6Cfg.CachedRegionLength[k_q];
        nr_rules  = clamp_rules(CVA6Cfg.NrCachedRegionRules);
      end
      default: ;
    endcase
  end

  assign rule_hit  = range_check(rule_base, rule_len, addr_q);
  assign last_rule = ({1'b0, k_q} == nr_rules - RuleCntW'(1));

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    kind_d  = kind_q;
    id_d    = id_q;
    hit_d   = hit_q;
    rule_d  = rule_q;
    k_d     = k_q;
    unique case (state_q)
      IDLE: begin
        if (handshake) begin
          addr_d  = req_addr_i[gnt_idx];
          kind_d  = pma_kind_e'(req_kind_i[gnt_idx]);
          id_d    = gnt_idx;
          k_d     = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (nr_rules == '0) begin
          hit_d   = 1'b0;
          rule_d  = '0;
          state_d = RESP;
        end else if (rule_hit) begin
          hit_d   = 1'b1;
          rule_d  = k_q;
          state_d = RESP;
        end else if (last_rule) begin
          hit_d   = 1'b0;
          rule_d  = '0;
          state_d = RESP;
        end else begin
          k_d = k_q + 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      kind_q  <= NONIDEM;
      id_q    <= '0;
      hit_q   <= 1'b0;
      rule_q  <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      kind_q  <= kind_d;
      id_q    <= id_d;
      hit_q   <= hit_d;
      rule_q  <= rule_d;
      k_q     <= k_d;
    end
  end

  assign req_ready_o = gnt;
  assign rsp_valid_o = (state_q == RESP);
  assign rsp_id_o    = id_q;
  assign rsp_hit_o   = hit_q;
  assign rsp_rule_o  = rule_q;

endmodule

// File: tb/tb_pma_seq_checker.sv
// Directed self-checking bench for pma_seq_checker with a two-requester,
// three-table configuration; inputs change at +1 after posedge, outputs are sampled at +3.
module tb_pma_seq_checker;
  import config_pkg::*;

  function automatic cva6_cfg_t make_cfg();
    cva6_cfg_t c;
    c = cva6_cfg_empty;
    c.NrNonIdempotentRules     = 1;
    c.NonIdempotentAddrBase[0] = 64'h0;
    c.NonIdempotentLength[0]   = 64'h8000_0000;
    c.NrExecuteRegionRules     = 2;
    c.ExecuteRegionAddrBase[0] = 64'h1_0000;
    c.ExecuteRegionLength[0]   = 64'h1_0000;
    c.ExecuteRegionAddrBase[1] = 64'h8000_0000;
    c.ExecuteRegionLength[1]   = 64'h4000_0000;
    c.NrCachedRegionRules      = 0;
    return c;
  endfunction

  localparam cva6_cfg_t BenchCfg = make_cfg();

  logic            clk = 1'b0;
  logic            rst_i;
  logic [1:0]      req_valid_i;
  logic [1:0]      req_ready_o;
  logic [1:0][63:0] req_addr_i;
  logic [1:0][1:0] req_kind_i;
  logic            rsp_valid_o;
  logic            rsp_ready_i;
  logic [0:0]      rsp_id_o;
  logic            rsp_hit_o;
  logic [3:0]      rsp_rule_o;

  int n_checks = 0;
  int n_fail   = 0;

  pma_seq_checker #(.CVA6Cfg(BenchCfg), .NrReq(2)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_addr_i  (req_addr_i),
    .req_kind_i  (req_kind_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_id_o    (rsp_id_o),
    .rsp_hit_o   (rsp_hit_o),
    .rsp_rule_o  (rsp_rule_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Entered and left at +1 of an IDLE cycle with rsp_ready_i = 1.
  task automatic lookup(input string tag, input logic [0:0] r, input logic [1:0] kind,
                        input logic [63:0] addr, input int exp_lat,
                        input logic exp_hit, input logic [3:0] exp_rule);
    int n;
    req_valid_i[r] = 1'b1;
    req_addr_i[r]  = addr;
    req_kind_i[r]  = kind;
    #2;
    n = 0;
    while (!req_ready_o[r] && n < 20) begin
      @(posedge clk); #3;
      n++;
    end
    check({tag, " grant"}, 64'(req_ready_o[r]), 64'd1);
    @(posedge clk); #1;
    req_valid_i[r] = 1'b0;
    #2;
    n = 1;
    while (!rsp_valid_o && n < 40) begin
      @(posedge clk); #3;
      n++;
    end
    check({tag, " latency"}, 64'(n), 64'(exp_lat));
    check({tag, " hit"}, 64'(rsp_hit_o), 64'(exp_hit));
    check({tag, " rule"}, 64'(rsp_rule_o), 64'(exp_rule));
    check({tag, " id"}, 64'(rsp_id_o), 64'(r));
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_i       = 1'b1;
    req_valid_i = '0;
    req_addr_i  = '0;
    req_kind_i  = '0;
    rsp_ready_i = 1'b1;

    // Reset: outputs must be zero during and right after reset.
    repeat (3) @(posedge clk);
    #3;
    check("rst valid", 64'(rsp_valid_o), 64'd0);
    check("rst ready", 64'(req_ready_o), 64'd0);
    check("rst hit", 64'(rsp_hit_o), 64'd0);
    check("rst rule", 64'(rsp_rule_o), 64'd0);
    check("rst id", 64'(rsp_id_o), 64'd0);
    @(posedge clk); #1;
    rst_i = 1'b0;
    #2;
    check("post-rst valid", 64'(rsp_valid_o), 64'd0);
    check("post-rst hit", 64'(rsp_hit_o), 64'd0);
    @(posedge clk); #1;

    // Directed lookups: tag, requester, kind, address, latency, hit, rule.
    lookup("s1_late_hit",   1'b0, 2'd1, 64'h8000_1000,          3, 1'b1, 4'd1);
    lookup("s2_end_excl",   1'b0, 2'd1, 64'h2_0000,             3, 1'b0, 4'd0);
    lookup("exec_rule0",    1'b1, 2'd1, 64'h1_0000,             2, 1'b1, 4'd0);
    lookup("exec_r1_last",  1'b1, 2'd1, 64'hBFFF_FFFF,          3, 1'b1, 4'd1);
    lookup("nonidem_last",  1'b1, 2'd0, 64'h7FFF_FFFF,          2, 1'b1, 4'd0);
    lookup("nonidem_end",   1'b1, 2'd0, 64'h8000_0000,          2, 1'b0, 4'd0);
    lookup("s3_cache",      1'b0, 2'd2, 64'h1_0000,             2, 1'b0, 4'd0);
    lookup("s3_rsvd",       1'b0, 2'd3, 64'h0,                  2, 1'b0, 4'd0);
    lookup("exec_top",      1'b0, 2'd1, 64'hFFFF_FFFF_FFFF_FFFF, 3, 1'b0, 4'd0);

    // Backpressure: response held for 5 cycles while req1 waits.
    rsp_ready_i    = 1'b0;
    req_valid_i[0] = 1'b1;
    req_addr_i[0]  = 64'h8000_0010;
    req_kind_i[0]  = 2'd1;
    #2;
    check("bp grant", 64'(req_ready_o), 64'b01);
    @(posedge clk); #1;
    req_valid_i[0] = 1'b0;
    req_valid_i[1] = 1'b1;
    req_addr_i[1]  = 64'h0;
    req_kind_i[1]  = 2'd0;
    #2;
    n = 1;
    while (!rsp_valid_o && n < 40) begin
      @(posedge clk); #3;
      n++;
    end
    check("bp latency", 64'(n), 64'd3);
    for (int i = 0; i < 5; i++) begin
      check("bp valid", 64'(rsp_valid_o), 64'd1);
      check("bp hit", 64'(rsp_hit_o), 64'd1);
      check("bp rule", 64'(rsp_rule_o), 64'd1);
      check("bp id", 64'(rsp_id_o), 64'd0);
      check("bp ready", 64'(req_ready_o), 64'd0);
      if (i < 4) begin
        @(posedge clk); #3;
      end
    end
    rsp_ready_i    = 1'b1;
    req_valid_i[1] = 1'b0;
    @(posedge clk); #3;
    check("bp done valid", 64'(rsp_valid_o), 64'd0);
    check("bp done ready", 64'(req_ready_o), 64'd0);
    @(posedge clk); #3;
    check("bp single resp", 64'(rsp_valid_o), 64'd0);
    @(posedge clk); #1;

    // Reset pulsed during SCAN: lookup is dropped and priority returns to req0.
    req_valid_i[0] = 1'b1;
    req_addr_i[0]  = 64'h8000_1000;
    req_kind_i[0]  = 2'd1;
    #2;
    check("mid-rst grant", 64'(req_ready_o), 64'b01);
    @(posedge clk); #1;
    req_valid_i[0] = 1'b0;
    rst_i          = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    #2;
    check("mid-rst valid", 64'(rsp_valid_o), 64'd0);
    check("mid-rst hit", 64'(rsp_hit_o), 64'd0);
    check("mid-rst rule", 64'(rsp_rule_o), 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #3;
      check("mid-rst no resp", 64'(rsp_valid_o), 64'd0);
    end
    @(posedge clk); #1;

    // Fairness: both requesters valid for four lookups.
    req_valid_i   = 2'b11;
    req_addr_i[0] = 64'h1_0000;
    req_kind_i[0] = 2'd2;
    req_addr_i[1] = 64'h8000_0000;
    req_kind_i[1] = 2'd1;
    for (int i = 0; i < 4; i++) begin
      logic odd;
      odd = (i % 2) == 1;
      #2;
      check("fair grant", 64'(req_ready_o), odd ? 64'b10 : 64'b01);
      @(posedge clk); #3;
      check("fair busy", 64'(req_ready_o), 64'd0);
      n = 1;
      while (!rsp_valid_o && n < 40) begin
        @(posedge clk); #3;
        n++;
      end
      check("fair latency", 64'(n), odd ? 64'd3 : 64'd2);
      check("fair id", 64'(rsp_id_o), 64'(odd));
      check("fair hit", 64'(rsp_hit_o), 64'(odd));
      check("fair rule", 64'(rsp_rule_o), 64'(odd));
      @(posedge clk); #1;
    end
    req_valid_i = '0;
    @(posedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
